// File: rtl/ahbl_cache_bridge.sv
// AHB-Lite slave that turns data-bus transfers into one-cycle cache_ctrl requests.
// It holds the request fields stable and stretches HREADY until the cache is done.
module ahbl_cache_bridge #(
    parameter int W_ADDR       = 32,
    parameter int BUSY_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hsel,
    input  logic [1:0]        ahbls_htrans,
    input  logic              ahbls_hwrite,
    input  logic [2:0]        ahbls_hsize,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hready,
    input  logic [31:0]       ahbls_hwdata,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    output logic [31:0]       ahbls_hrdata,
    output logic              c_rd_en,
    output logic              c_wr_en,
    output logic [W_ADDR-1:0] c_addr,
    output logic [31:0]       c_wdata,
    output logic [3:0]        c_mask,
    input  logic [31:0]       c_rdata,
    input  logic              c_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_ERR1  = 3'd6;
    localparam logic [2:0] S_ERR2  = 3'd7;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [2:0]  accept_next;
    logic        write_q;
    logic        stale_busy;
    logic [31:0] busy_cnt;
    logic [31:0] rdata_q;
    logic [3:0]  mask_next;
    logic        illegal;
    logic        hit_done;
    logic        resp_slot;
    logic        accept;
    logic        issue_go;
    logic        timeout_hit;
    logic        unused_htrans0;

    assign unused_htrans0 = ahbls_htrans[0];

    // A read hit completes in CHECK itself, so that cycle doubles as the response slot.
    assign hit_done    = (state == S_CHECK) && !c_busy;
    assign resp_slot   = (state == S_IDLE) || (state == S_RESP) || hit_done;
    assign accept      = resp_slot && ahbls_hsel && ahbls_htrans[1] && ahbls_hready;
    assign issue_go    = (state == S_ISSUE) && !(stale_busy && c_busy);
    assign timeout_hit = (BUSY_TIMEOUT != 0) && c_busy
                         && (busy_cnt == 32'(BUSY_TIMEOUT - 1));

    always_comb begin
        illegal   = 1'b0;
        mask_next = 4'b1111;
        case (ahbls_hsize)
            3'd0: mask_next = 4'b0001 << ahbls_haddr[1:0];
            3'd1: begin
                mask_next = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
                illegal   = ahbls_haddr[0];
            end
            3'd2: illegal = (ahbls_haddr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        accept_next = illegal ? S_ERR1 : (ahbls_hwrite ? S_LATCH : S_ISSUE);
        state_next  = state;
        case (state)
            S_IDLE, S_RESP: state_next = accept ? accept_next : S_IDLE;
            S_LATCH:        state_next = S_ISSUE;
            S_ISSUE:        state_next = issue_go ? S_CHECK : S_ISSUE;
            S_CHECK:        state_next = c_busy ? S_WAIT : (accept ? accept_next : S_IDLE);
            S_WAIT: begin
                if (!c_busy)
                    state_next = S_RESP;
                else if (timeout_hit)
                    state_next = S_ERR1;
            end
            S_ERR1:         state_next = S_ERR2;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            write_q    <= 1'b0;
            stale_busy <= 1'b0;
            busy_cnt   <= 32'd0;
            rdata_q    <= 32'd0;
            c_addr     <= '0;
            c_wdata    <= 32'd0;
            c_mask     <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                c_addr  <= {ahbls_haddr[W_ADDR-1:2], 2'b00};
                c_mask  <= mask_next;
                write_q <= ahbls_hwrite;
            end
            if (state == S_LATCH)
                c_wdata <= ahbls_hwdata;
            if (issue_go) begin
                stale_busy <= 1'b0;
                if (!write_q)
                    rdata_q <= c_rdata;
            end
            if (state == S_CHECK && c_busy)
                busy_cnt <= 32'd0;
            if (state == S_WAIT) begin
                busy_cnt <= busy_cnt + 32'd1;
                if (!c_busy && !write_q)
                    rdata_q <= c_rdata;
                // The abandoned cache operation may still be running; gate the next issue on it.
                if (timeout_hit)
                    stale_busy <= 1'b1;
            end
        end
    end

    assign ahbls_hready_resp = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR2) || hit_done;
    assign ahbls_hresp       = (state == S_ERR1) || (state == S_ERR2);
    assign ahbls_hrdata      = rdata_q;
    assign c_rd_en           = issue_go && !write_q;
    assign c_wr_en           = issue_go && write_q;

endmodule
